div32: RTL and testbench
========================

DIV32 -- requirements
Module: div32

Interface
REQ-001 The block SHALL have no parameters; the width is fixed at 32 bits.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 clrn  input  1  reset, asynchronous and active-low; clrn=0 SHALL clear all state immediately, with no dependence on clk.
REQ-004 a  input  32  dividend, sampled only on the accepting edge.
REQ-005 b  input  32  divisor, sampled only on the accepting edge.
REQ-006 sign  input  1  operation type (1 = signed two's-complement, 0 = unsigned), sampled only on the accepting edge.
REQ-007 start  input  1  request a division.
REQ-008 q  output  32  quotient, registered.
REQ-009 r  output  32  remainder, registered.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 ready  output  1  one-cycle pulse marking that q, r and dbz are valid.
REQ-012 dbz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-013 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-014 Accepting edge: a rising edge in IDLE or DONE with start=1; a, b and sign SHALL be captured on that edge.
REQ-015 On accept with b!=0, the state SHALL become RUN, busy SHALL be 1, and the iteration counter SHALL be 0.
REQ-016 RUN SHALL perform one restoring radix-2 step per cycle on the operand magnitudes (|a|, |b| when sign=1; raw values when sign=0).
REQ-017 After 32 RUN cycles, the state SHALL become DONE: busy=0, ready=1, q and r updated on that same edge.
REQ-018 Latency SHALL be 33 edges from the accepting edge to the edge that raises ready, so that ready is high in cycle 33 after start.
REQ-019 On accept with b=0, the state SHALL go directly to DONE on the accepting edge.
REQ-020 For b=0, the outputs SHALL be q=32'hFFFFFFFF, r=a, dbz=1, ready=1 in the next cycle, and busy SHALL stay 0.
REQ-021 ready SHALL be high for exactly one cycle; DONE SHALL return to IDLE on the next edge unless that edge accepts a new start.
REQ-022 q, r and dbz SHALL hold their values from the completing edge until the next completing edge.
REQ-023 dbz SHALL clear at the completion of any operation with b!=0.
REQ-024 The signed quotient SHALL truncate toward zero; it SHALL be negative when sign(a) differs from sign(b) and the magnitude quotient is nonzero.
REQ-025 The signed remainder SHALL take the sign of a, and SHALL satisfy a = q*b + r with |r| < |b|.
REQ-026 Signed overflow (a=32'h80000000, b=32'hFFFFFFFF) SHALL give q=32'h80000000, r=0, dbz=0, with normal latency.
REQ-027 A start asserted while busy=1 SHALL be ignored; it SHALL be neither queued nor disruptive to the operation in progress.
REQ-028 Changes to a, b or sign during RUN SHALL have no effect on the result.
REQ-029 A start held high continuously SHALL give back-to-back operations: accepted on the DONE edge, with ready pulsing every 33 cycles.

Reset
REQ-030 While clrn=0, outputs SHALL be q=0, r=0, busy=0, ready=0, dbz=0, with the state IDLE and the counter 0.
REQ-031 Reset asserted mid-RUN SHALL abort the operation, produce no ready pulse, and leave nothing latched.
REQ-032 After reset is released, the first accepting edge SHALL behave exactly as after power-up.

Verification
REQ-033 Unsigned: a=100, b=7, sign=0, start for 1 cycle -> busy for 32 cycles, ready in cycle 33, q=14, r=2, dbz=0.
REQ-034 Signed: a=-100 (32'hFFFFFF9C), b=7, sign=1 -> q=-14 (32'hFFFFFFF2), r=-2 (32'hFFFFFFFE); also a=100, b=-7 -> q=-14, r=2.
REQ-035 Divide by zero: a=32'h12345678, b=0 -> ready in the cycle after start, q=32'hFFFFFFFF, r=32'h12345678, dbz=1, busy never asserted.
REQ-036 Overflow plus unsigned extreme: a=32'h80000000, b=32'hFFFFFFFF, sign=1 -> q=32'h80000000, r=0; same operands with sign=0 -> q=0, r=32'h80000000.
REQ-037 Start during busy: start a=50, b=5, then pulse start with a=9, b=3 at cycle 10 -> a single ready in cycle 33 with q=10, r=0, and no second ready.
REQ-038 Reset mid-op: clrn=0 at cycle 15 of a run -> all outputs 0 immediately; after release no ready appears until a new start.

Source files
------------

// File: rtl/div32_if.sv
// Handshake and data bundle for the 32-bit divider: operands and start in,
// quotient/remainder and status out.
interface div_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic        start;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        ready;
    logic        dbz;

    modport master (
        output a, b, sign, start,
        input  q, r, busy, ready, dbz
    );

    modport slave (
        input  a, b, sign, start,
        output q, r, busy, ready, dbz
    );
endinterface

// File: rtl/div32.sv
// 32-bit signed/unsigned restoring radix-2 divider, one quotient bit per cycle.
//
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | 32 restoring steps on operand magnitudes, busy high
//  DONE  | results valid, ready high for this single cycle
module div32 (
    input  logic clk,
    input  logic clrn,
    div_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvsr;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] q_reg;
    logic [31:0] r_reg;
    logic        dbz_reg;

    logic        accept;
    logic        last_step;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;

    assign accept    = bus.start && (state != RUN);
    assign last_step = (state == RUN) && (cnt == 5'd31);

    // Shift the next dividend bit into the partial remainder and keep the
    // subtraction only when it does not borrow.
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvsr};
        if (diff[32]) begin
            rem_nxt = shifted[31:0];
            quo_nxt = {quo[30:0], 1'b0};
        end else begin
            rem_nxt = diff[31:0];
            quo_nxt = {quo[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = (bus.b == 32'd0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (cnt == 5'd31) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt     <= 5'd0;
            quo     <= 32'd0;
            rem     <= 32'd0;
            dvsr    <= 32'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            q_reg   <= 32'd0;
            r_reg   <= 32'd0;
            dbz_reg <= 1'b0;
        end else if (accept) begin
            cnt   <= 5'd0;
            rem   <= 32'd0;
            quo   <= (bus.sign && bus.a[31]) ? -bus.a : bus.a;
            dvsr  <= (bus.sign && bus.b[31]) ? -bus.b : bus.b;
            neg_q <= bus.sign && (bus.a[31] ^ bus.b[31]);
            neg_r <= bus.sign && bus.a[31];
            // Divide by zero completes on the accepting edge itself.
            if (bus.b == 32'd0) begin
                q_reg   <= 32'hFFFF_FFFF;
                r_reg   <= bus.a;
                dbz_reg <= 1'b1;
            end
        end else if (state == RUN) begin
            cnt <= cnt + 5'd1;
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (last_step) begin
                q_reg   <= neg_q ? -quo_nxt : quo_nxt;
                r_reg   <= neg_r ? -rem_nxt : rem_nxt;
                dbz_reg <= 1'b0;
            end
        end
    end

    assign bus.q     = q_reg;
    assign bus.r     = r_reg;
    assign bus.dbz   = dbz_reg;
    assign bus.busy  = (state == RUN);
    assign bus.ready = (state == DONE);

endmodule

// File: tb/tb_div32.sv
// Self-checking bench for div32: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div32;

    logic clk;
    logic clrn;
    int   n_assert;
    int   n_fail;

    div_if bus ();

    div32 u_dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic ms,
                                  output logic [31:0] eq, output logic [31:0] er, output logic edbz);
        longint sa;
        longint sb;
        if (mb == 32'd0) begin
            eq   = 32'hFFFF_FFFF;
            er   = ma;
            edbz = 1'b1;
        end else if (ms) begin
            sa   = longint'($signed(ma));
            sb   = longint'($signed(mb));
            eq   = 32'(sa / sb);
            er   = 32'(sa % sb);
            edbz = 1'b0;
        end else begin
            eq   = ma / mb;
            er   = ma % mb;
            edbz = 1'b0;
        end
    endfunction

    // Issue one single-cycle start, scramble inputs during the run, and check
    // latency, busy duration, results, the one-cycle ready and result hold.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                         input int inject, input string tag);
        logic [31:0] eq, er, gq, gr;
        logic        edbz, gdbz;
        int          lat, busy_n, extra;
        bit          got;
        model(ta, tb_v, ts, eq, er, edbz);
        @(negedge clk);
        bus.a = ta; bus.b = tb_v; bus.sign = ts; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 99; busy_n = 0; got = 0;
        gq = 'x; gr = 'x; gdbz = 1'bx;
        for (int k = 1; k <= 40 && !got; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.ready) begin
                got = 1; lat = k; gq = bus.q; gr = bus.r; gdbz = bus.dbz;
            end
            bus.a = $urandom; bus.b = $urandom; bus.sign = 1'($urandom);
            bus.start = (inject != 0) && (k == inject);
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 32'(lat), (tb_v == 32'd0) ? 32'd1 : 32'd33);
        check({tag, " busy_cycles"}, 32'(busy_n), (tb_v == 32'd0) ? 32'd0 : 32'd32);
        check({tag, " q"}, gq, eq);
        check({tag, " r"}, gr, er);
        check({tag, " dbz"}, {31'd0, gdbz}, {31'd0, edbz});
        @(negedge clk);
        check({tag, " ready_drop"}, {31'd0, bus.ready}, 32'd0);
        check({tag, " q_hold"}, bus.q, eq);
        if (inject != 0) begin
            extra = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.ready || bus.busy) extra++;
            end
            check({tag, " no_second_op"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra, rb, eq, er;
        logic        rs, edbz;
        int          k1, k2, quiet;
        n_assert = 0;
        n_fail   = 0;
        clrn = 1'b0;
        bus.a = '0; bus.b = '0; bus.sign = 1'b0; bus.start = 1'b0;

        repeat (3) @(negedge clk);
        check("rst q", bus.q, 32'd0);
        check("rst r", bus.r, 32'd0);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst ready", {31'd0, bus.ready}, 32'd0);
        check("rst dbz", {31'd0, bus.dbz}, 32'd0);
        clrn = 1'b1;

        do_op(32'd100, 32'd7, 1'b0, 0, "udiv_100_7");
        do_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0, "sdiv_m100_7");
        do_op(32'd100, 32'hFFFF_FFF9, 1'b1, 0, "sdiv_100_m7");
        do_op(32'h1234_5678, 32'd0, 1'b0, 0, "dbz_u");
        do_op(32'h8765_4321, 32'd0, 1'b1, 0, "dbz_s");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_overflow");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "u_extreme");
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "u_max_by_1");
        do_op(32'd5, 32'd9, 1'b0, 0, "u_small");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "s_m1_m1");
        do_op(32'hFFFF_FFF9, 32'd7, 1'b1, 0, "s_m7_7");
        do_op(32'd50, 32'd5, 1'b0, 10, "start_in_busy");

        // Reset in the middle of a run
        @(negedge clk);
        bus.a = 32'd1000; bus.b = 32'd3; bus.sign = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        clrn = 1'b0;
        #1;
        check("midrst q", bus.q, 32'd0);
        check("midrst r", bus.r, 32'd0);
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst ready", {31'd0, bus.ready}, 32'd0);
        check("midrst dbz", {31'd0, bus.dbz}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        quiet = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ready || bus.busy) quiet++;
        end
        check("midrst quiet", 32'(quiet), 32'd0);
        do_op(32'd1000, 32'd3, 1'b0, 0, "after_rst");

        // Start held high: back-to-back operations
        model(32'd1000, 32'd33, 1'b0, eq, er, edbz);
        @(negedge clk);
        bus.a = 32'd1000; bus.b = 32'd33; bus.sign = 1'b0; bus.start = 1'b1;
        k1 = 99; k2 = 99;
        for (int k = 1; k <= 80 && k2 == 99; k++) begin
            @(negedge clk);
            if (bus.ready) begin
                if (k1 == 99) begin
                    k1 = k;
                    check("b2b q1", bus.q, eq);
                end else begin
                    k2 = k;
                    check("b2b r2", bus.r, er);
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        check("b2b first", 32'(k1), 32'd33);
        check("b2b period", 32'(k2 - k1), 32'd33);
        @(negedge clk);
        check("b2b idle busy", {31'd0, bus.busy}, 32'd0);
        check("b2b idle ready", {31'd0, bus.ready}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rs = 1'($urandom);
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            do_op(ra, rb, rs, 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
